// File: rtl/rename_alloc_ctrl.sv
// Rename allocation controller: speculative arch-to-physical map, free-list pop/push
// handshake and one-cycle flush recovery that restores the free list and map.
module rename_alloc_ctrl #(
  parameter int ARCHNUM = 32,
  parameter int TAGWIDE = 5,
  localparam int ARCHW  = $clog2(ARCHNUM)
) (
  input  logic               Clk,
  input  logic               Rest,
  input  logic               RnValid,
  input  logic               RnDestEn,
  input  logic [ARCHW-1:0]   RnDest,
  input  logic [ARCHW-1:0]   RnSrc1,
  input  logic [ARCHW-1:0]   RnSrc2,
  output logic               RnReady,
  output logic               RnOutValid,
  output logic [TAGWIDE-1:0] RnPDest,
  output logic [TAGWIDE-1:0] RnPSrc1,
  output logic               RnPSrc1Vld,
  output logic [TAGWIDE-1:0] RnPSrc2,
  output logic               RnPSrc2Vld,
  output logic [TAGWIDE-1:0] RnOldPDest,
  output logic               RnOldVld,
  input  logic               CmValid,
  input  logic [ARCHW-1:0]   CmArch,
  input  logic [TAGWIDE-1:0] CmPDest,
  input  logic               Flush,
  output logic               FlRable,
  input  logic [TAGWIDE-1:0] FlPreOut,
  input  logic               FlEmpty,
  output logic               FlWable,
  output logic [TAGWIDE-1:0] FlDin,
  output logic               FlClean
);

  typedef enum logic [0:0] {NORMAL = 1'b0, RECOVER = 1'b1} state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 ready_s;
  logic                 fire_s;
  logic                 alloc_s;
  logic                 wable_s;
  logic                 clean_s;
  logic [TAGWIDE-1:0]   din_s;
  logic [ARCHNUM-1:0]   map_vld_r;
  logic [TAGWIDE-1:0]   map_tag_r [ARCHNUM];

  // Next-state and free-list handshake decode; reset masks every strobe.
  always_comb begin
    state_nxt_s = NORMAL;
    ready_s     = 1'b0;
    wable_s     = 1'b0;
    clean_s     = 1'b0;
    din_s       = '0;
    if (Rest) begin
      state_nxt_s = NORMAL;
    end else begin
      case (state_r)
        NORMAL: begin
          state_nxt_s = Flush ? RECOVER : NORMAL;
          ready_s     = !Flush && (!RnDestEn || !FlEmpty);
          wable_s     = CmValid && !Flush;
        end
        RECOVER: begin
          state_nxt_s = Flush ? RECOVER : NORMAL;
          clean_s     = 1'b1;
        end
        default: begin
          state_nxt_s = NORMAL;
        end
      endcase
      if (wable_s) begin
        din_s = CmPDest;
      end else begin
        din_s = '0;
      end
    end
  end

  assign fire_s  = RnValid && ready_s;
  assign alloc_s = fire_s && RnDestEn;
  assign RnReady = ready_s;
  assign FlRable = alloc_s;
  assign FlWable = wable_s;
  assign FlDin   = din_s;
  assign FlClean = clean_s;

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_r <= NORMAL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Speculative map: recovery wipes valids, commit retires a matching tag, rename write wins last.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      map_vld_r <= '0;
      for (int i = 0; i < ARCHNUM; i++) begin
        map_tag_r[i] <= '0;
      end
    end else begin
      if (state_r == RECOVER) begin
        map_vld_r <= '0;
      end else if (CmValid && map_vld_r[CmArch] && (map_tag_r[CmArch] == CmPDest)) begin
        map_vld_r[CmArch] <= 1'b0;
      end else begin
        map_vld_r <= map_vld_r;
      end
      if (alloc_s) begin
        map_vld_r[RnDest] <= 1'b1;
        map_tag_r[RnDest] <= FlPreOut;
      end
    end
  end

  // Registered rename results, captured from pre-write map contents in the fire cycle.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      RnOutValid <= 1'b0;
      RnPDest    <= '0;
      RnPSrc1    <= '0;
      RnPSrc1Vld <= 1'b0;
      RnPSrc2    <= '0;
      RnPSrc2Vld <= 1'b0;
      RnOldPDest <= '0;
      RnOldVld   <= 1'b0;
    end else begin
      RnOutValid <= fire_s && !Flush;
      if (fire_s) begin
        RnPDest    <= RnDestEn ? FlPreOut : '0;
        RnPSrc1    <= map_tag_r[RnSrc1];
        RnPSrc1Vld <= map_vld_r[RnSrc1];
        RnPSrc2    <= map_tag_r[RnSrc2];
        RnPSrc2Vld <= map_vld_r[RnSrc2];
        RnOldPDest <= RnDestEn ? map_tag_r[RnDest] : '0;
        RnOldVld   <= RnDestEn && map_vld_r[RnDest];
      end
    end
  end

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Bench for rename_alloc_ctrl: directed scenarios plus random traffic checked against
// a queue-based free list and array map reference model.
module tb_rename_alloc_ctrl;

  logic       Clk = 1'b0;
  logic       Rest, RnValid, RnDestEn, CmValid, Flush, FlEmpty;
  logic [4:0] RnDest, RnSrc1, RnSrc2, CmArch, CmPDest, FlPreOut;
  logic       RnReady, RnOutValid, RnPSrc1Vld, RnPSrc2Vld, RnOldVld, FlRable, FlWable, FlClean;
  logic [4:0] RnPDest, RnPSrc1, RnPSrc2, RnOldPDest, FlDin;

  rename_alloc_ctrl dut (
    .Clk(Clk), .Rest(Rest), .RnValid(RnValid), .RnDestEn(RnDestEn), .RnDest(RnDest),
    .RnSrc1(RnSrc1), .RnSrc2(RnSrc2), .RnReady(RnReady), .RnOutValid(RnOutValid),
    .RnPDest(RnPDest), .RnPSrc1(RnPSrc1), .RnPSrc1Vld(RnPSrc1Vld), .RnPSrc2(RnPSrc2),
    .RnPSrc2Vld(RnPSrc2Vld), .RnOldPDest(RnOldPDest), .RnOldVld(RnOldVld),
    .CmValid(CmValid), .CmArch(CmArch), .CmPDest(CmPDest), .Flush(Flush),
    .FlRable(FlRable), .FlPreOut(FlPreOut), .FlEmpty(FlEmpty), .FlWable(FlWable),
    .FlDin(FlDin), .FlClean(FlClean)
  );

  always #5 Clk = ~Clk;

  typedef struct {logic [4:0] a; logic [4:0] t;} inf_t;

  int         n_vec = 0;
  int         n_err = 0;
  bit         m_vld [32];
  logic [4:0] m_tag [32];
  bit         m_rec;
  logic [4:0] fl_q [$];
  inf_t       inflight [$];
  bit         e_ov, e_s1v, e_s2v, e_oldv, e_after_rst;
  logic [4:0] e_pd, e_s1, e_s2, e_old;
  logic       s_ready, s_clean, s_wable;
  logic [4:0] s_din;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void fl_init();
    fl_q.delete();
    for (int i = 0; i < 8; i++) fl_q.push_back(5'(4 * i + 3));
  endfunction

  function automatic void model_reset();
    m_rec = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_vld[i] = 1'b0;
      m_tag[i] = 5'd0;
    end
    fl_init();
    inflight.delete();
  endfunction

  // One clock: check combinational strobes, advance the model, check registered outputs.
  task automatic cycle();
    bit ready, fire, rable, wable, clean;
    logic [4:0] head;
    #1;
    head  = (fl_q.size() != 0) ? fl_q[0] : 5'd0;
    ready = !Rest && !m_rec && !Flush && (!RnDestEn || fl_q.size() != 0);
    fire  = RnValid && ready;
    rable = fire && RnDestEn;
    wable = !Rest && !m_rec && !Flush && CmValid;
    clean = !Rest && m_rec;
    s_ready = RnReady; s_clean = FlClean; s_wable = FlWable; s_din = FlDin;
    check_val("rn_ready", RnReady, ready);
    check_val("fl_rable", FlRable, rable);
    check_val("fl_wable", FlWable, wable);
    check_val("fl_clean", FlClean, clean);
    if (wable) check_val("fl_din", FlDin, CmPDest);
    if (Rest) begin
      model_reset();
      e_ov = 1'b0;
      e_after_rst = 1'b1;
    end else begin
      e_after_rst = 1'b0;
      e_ov = fire;
      if (fire) begin
        e_pd   = RnDestEn ? head : 5'd0;
        e_s1   = m_tag[RnSrc1]; e_s1v = m_vld[RnSrc1];
        e_s2   = m_tag[RnSrc2]; e_s2v = m_vld[RnSrc2];
        e_old  = m_tag[RnDest]; e_oldv = RnDestEn && m_vld[RnDest];
      end
      if (m_rec) begin
        for (int i = 0; i < 32; i++) m_vld[i] = 1'b0;
      end else if (CmValid && m_vld[CmArch] && m_tag[CmArch] == CmPDest) begin
        m_vld[CmArch] = 1'b0;
      end
      if (rable) begin
        m_vld[RnDest] = 1'b1;
        m_tag[RnDest] = head;
        void'(fl_q.pop_front());
        inflight.push_back(inf_t'{a: RnDest, t: head});
      end
      if (wable) fl_q.push_back(CmPDest);
      if (clean) begin
        fl_init();
        inflight.delete();
      end
      m_rec = Flush;
    end
    @(posedge Clk);
    #1;
    check_val("out_valid", RnOutValid, e_ov);
    if (e_after_rst) begin
      check_val("rst_outs", {RnPDest, RnPSrc1, RnPSrc2, RnOldPDest, RnPSrc1Vld, RnPSrc2Vld, RnOldVld}, 32'd0);
    end
    if (e_ov) begin
      check_val("pdest", RnPDest, e_pd);
      check_val("src1_vld", RnPSrc1Vld, e_s1v);
      if (e_s1v) check_val("src1_tag", RnPSrc1, e_s1);
      check_val("src2_vld", RnPSrc2Vld, e_s2v);
      if (e_s2v) check_val("src2_tag", RnPSrc2, e_s2);
      check_val("old_vld", RnOldVld, e_oldv);
      if (e_oldv) check_val("old_tag", RnOldPDest, e_old);
    end
    FlPreOut = (fl_q.size() != 0) ? fl_q[0] : 5'd0;
    FlEmpty  = (fl_q.size() == 0);
    @(negedge Clk);
  endtask

  task automatic drv(input bit rst, input bit fl, input bit rv, input bit de,
                     input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                     input bit cv, input logic [4:0] ca, input logic [4:0] cp);
    Rest = rst; Flush = fl; RnValid = rv; RnDestEn = de;
    RnDest = d; RnSrc1 = s1; RnSrc2 = s2;
    CmValid = cv; CmArch = ca; CmPDest = cp;
    cycle();
  endtask

  task automatic do_reset();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
  endtask

  initial begin
    bit rst, fl, rv, de, cv;
    logic [4:0] ca, cp;
    inf_t c;
    Rest = 1'b1; Flush = 1'b0; RnValid = 1'b0; RnDestEn = 1'b0;
    RnDest = 5'd0; RnSrc1 = 5'd0; RnSrc2 = 5'd0;
    CmValid = 1'b0; CmArch = 5'd0; CmPDest = 5'd0;
    model_reset();
    FlPreOut = fl_q[0];
    FlEmpty  = 1'b0;
    @(negedge Clk);
    do_reset();
    do_reset();

    // Drain the whole free list, then request one more.
    for (int i = 0; i < 8; i++) begin
      drv(1'b0, 1'b0, 1'b1, 1'b1, 5'(i + 1), 5'($urandom), 5'($urandom), 1'b0, 5'd0, 5'd0);
      check_val("drain_pdest", RnPDest, 32'(4 * i + 3));
    end
    drv(1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
    check_val("empty_ready", s_ready, 32'd0);

    // Source and old dest read the prior mapping of the same register.
    do_reset();
    drv(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
    drv(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0);
    check_val("bypass_src1", RnPSrc1, 32'd3);
    check_val("bypass_src1v", RnPSrc1Vld, 32'd1);
    check_val("bypass_old", RnOldPDest, 32'd3);
    check_val("bypass_oldv", RnOldVld, 32'd1);
    check_val("bypass_pdest", RnPDest, 32'd7);

    // Stale commit frees its tag but leaves the newer mapping; matching commit clears it.
    drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 5'd3);
    check_val("stale_wable", s_wable, 32'd1);
    check_val("stale_din", s_din, 32'd3);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0);
    check_val("stale_keep_tag", RnPSrc1, 32'd7);
    check_val("stale_keep_vld", RnPSrc1Vld, 32'd1);
    check_val("nodest_pdest", RnPDest, 32'd0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 5'd7);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0);
    check_val("match_clear_vld", RnPSrc1Vld, 32'd0);

    // Flush with three tags outstanding, then recovery restores the free list.
    do_reset();
    for (int i = 1; i <= 3; i++) drv(1'b0, 1'b0, 1'b1, 1'b1, 5'(i), 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
    drv(1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
    drv(1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
    check_val("recover_clean", s_clean, 32'd1);
    check_val("recover_ready", s_ready, 32'd0);
    drv(1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd1, 5'd0, 1'b0, 5'd0, 5'd0);
    check_val("post_flush_vld", RnPSrc1Vld, 32'd0);
    check_val("post_flush_pdest", RnPDest, 32'd3);

    // Commit alongside flush, then reset landing in the recovery cycle.
    drv(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd1, 5'd3);
    check_val("flush_cm_wable", s_wable, 32'd0);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
    check_val("rst_in_recover_clean", s_clean, 32'd0);
    drv(1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
    check_val("after_rst_clean", s_clean, 32'd0);
    check_val("after_rst_ready", s_ready, 32'd1);

    // Rename and matching commit to the same register: rename wins.
    do_reset();
    drv(1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
    drv(1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b1, 5'd9, 5'd3);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0, 5'd0, 5'd0);
    check_val("same_cycle_tag", RnPSrc1, 32'd7);
    check_val("same_cycle_vld", RnPSrc1Vld, 32'd1);

    // Random traffic with in-order commits of allocated tags.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom % 200) == 0;
      fl  = ($urandom % 25) == 0;
      rv  = ($urandom % 4) != 0;
      de  = ($urandom % 5) != 0;
      cv  = (inflight.size() != 0) && (($urandom % 3) == 0);
      ca  = 5'd0;
      cp  = 5'd0;
      if (cv) begin
        c  = inflight.pop_front();
        ca = (($urandom % 4) == 0) ? 5'($urandom) : c.a;
        cp = c.t;
      end
      drv(rst, fl, rv, de, 5'($urandom), 5'($urandom), 5'($urandom), cv, ca, cp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rename_alloc_ctrl.md
RENAME_ALLOC_CTRL -- requirements
Module: rename_alloc_ctrl

Interface
REQ-001 SHALL have parameters ARCHNUM=32 (architectural registers) and TAGWIDE=5 (free-list tag width, matches the free-list queue).
REQ-002 SHALL have ports: Clk  in  1  clock; Rest  in  1  reset, synchronous, active-high.
REQ-003 SHALL have rename inputs: RnValid  in  1  request; RnDestEn  in  1  has dest; RnDest/RnSrc1/RnSrc2  in  5 each  arch indices.
REQ-004 SHALL have RnReady  out  1  rename accepted this cycle when RnValid=1.
REQ-005 SHALL have registered rename outputs: RnOutValid 1; RnPDest 5; RnPSrc1 5; RnPSrc1Vld 1; RnPSrc2 5; RnPSrc2Vld 1; RnOldPDest 5; RnOldVld 1 (Vld=0 means read architectural file).
REQ-006 SHALL have commit inputs: CmValid 1; CmArch 5; CmPDest 5 (tag retired to architectural file).
REQ-007 SHALL have Flush  in  1  pipeline redirect.
REQ-008 SHALL have free-list ports: FlRable out 1 pop; FlPreOut in 5 head peek (combinational); FlEmpty in 1; FlWable out 1 push; FlDin out 5 freed tag; FlClean out 1 restore free list to its initial set.

Function
REQ-009 SHALL hold a speculative map: ARCHNUM entries of {Vld, Tag[4:0]}.
REQ-010 SHALL have FSM states NORMAL, RECOVER; Flush=1 in NORMAL -> RECOVER next cycle; RECOVER -> NORMAL after exactly 1 cycle; Flush held high keeps state RECOVER.
REQ-011 SHALL compute RnReady = (state==NORMAL) & !Flush & (!RnDestEn | !FlEmpty), combinationally.
REQ-012 SHALL define fire = RnValid & RnReady; FlRable = fire & RnDestEn; allocated tag = FlPreOut in the fire cycle.
REQ-013 SHALL read sources and old dest from map contents before this cycle's writes (RnSrc==RnDest returns the prior mapping).
REQ-014 SHALL on fire with RnDestEn write map[RnDest] <= {1, FlPreOut} at the clock edge.
REQ-015 SHALL register all rename outputs one cycle after fire (latency 1); RnOutValid=1 for exactly one cycle per fire; RnPDest=0 when RnDestEn=0.
REQ-016 SHALL on CmValid in NORMAL with !Flush drive FlWable=1, FlDin=CmPDest combinationally in the same cycle.
REQ-017 SHALL on CmValid clear map[CmArch].Vld only when Vld=1 and Tag==CmPDest (pre-update values).
REQ-018 SHALL, when a fired rename and a commit target the same arch index in one cycle, let the rename write win.
REQ-019 SHALL suppress FlWable when Flush=1 or state==RECOVER; the commit map-clear of REQ-017 still applies.
REQ-020 SHALL in RECOVER assert FlClean=1 for that cycle, clear every map Vld bit, force FlRable=0, RnReady=0.
REQ-021 SHALL on Flush force RnOutValid=0 in the following cycle, discarding any output registered from the flush cycle.

Reset
REQ-022 SHALL on Rest=1: state NORMAL, all map Vld=0, Tag=0, all registered outputs 0, RnOutValid=0.
REQ-023 SHALL on Rest=1 drive FlRable=0, FlWable=0, FlClean=0, RnReady=0.
REQ-024 SHALL give Rest priority over Flush, commit and rename in the same cycle.

Verification
REQ-025 Reset, then 8 back-to-back renames RnDest=1..8 -> RnPDest 3,7,11,15,19,23,27,31; 9th request sees FlEmpty=1 -> RnReady=0.
REQ-026 Rename r5 (gets 3), then rename src1=r5, dest=r5 -> RnPSrc1=3, RnPSrc1Vld=1, RnOldPDest=3, RnOldVld=1, RnPDest=7.
REQ-027 Commit CmArch=5, CmPDest=3 while map[5]=7 -> FlWable=1, FlDin=3, map[5] stays {1,7}; then commit CmPDest=7 -> map[5].Vld=0.
REQ-028 Flush with 3 tags allocated -> next cycle FlClean=1, RnReady=0; following cycle renames read Vld=0 and allocate 3 again.
REQ-029 Commit and Flush same cycle -> FlWable=0; Rest asserted during RECOVER -> state NORMAL, FlClean=0 next cycle.
REQ-030 Fired rename r9 and commit r9 with matching old tag in the same cycle -> map[9] holds the new tag, Vld=1.
